// File: rtl/data_compare_pkg.sv
// Shared definitions for the multi-cycle wide magnitude comparator.
package data_compare_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/DataCompare4.sv
// 4-bit cascade magnitude comparator: a differing nibble decides, equal passes iData.
module DataCompare4
  import data_compare_pkg::*;
(
  input  logic [NIB_W-1:0] iData_a,
  input  logic [NIB_W-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic [2:0]       oData
);

  always_comb begin
    oData = iData;
    if (iData_a > iData_b) begin
      oData = CMP_GT;
    end else if (iData_a < iData_b) begin
      oData = CMP_LT;
    end
  end

endmodule

// File: rtl/data_compare_seq.sv
// Wide magnitude comparator that walks one shared 4-bit cascade comparator over
// the operand nibbles, LSB first, and returns the result plus max/min operands.
module data_compare_seq
  import data_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData,
  output logic [WIDTH-1:0] oMax,
  output logic [WIDTH-1:0] oMin
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e             state_q, state_d;
  logic [2:0]         casc_q, casc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [2:0]         data_q, data_d;
  logic [WIDTH-1:0]   max_q, max_d, min_q, min_d;
  logic [2:0]         cmp_c;

  DataCompare4 u_cmp4 (
    .iData_a (sh_a_q[NIB_W-1:0]),
    .iData_b (sh_b_q[NIB_W-1:0]),
    .iData   (casc_q),
    .oData   (cmp_c)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      casc_q   <= CMP_EQ;
      cnt_q    <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 3'b000;
      max_q    <= '0;
      min_q    <= '0;
    end else begin
      state_q  <= state_d;
      casc_q   <= casc_d;
      cnt_q    <= cnt_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      max_q    <= max_d;
      min_q    <= min_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    casc_d   = casc_q;
    cnt_d    = cnt_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    data_d   = data_q;
    max_d    = max_q;
    min_d    = min_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          sh_a_d   = iData_a;
          sh_b_d   = iData_b;
          hold_a_d = iData_a;
          hold_b_d = iData_b;
          casc_d   = CMP_EQ;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        casc_d = cmp_c;
        sh_a_d = sh_a_q >> NIB_W;
        sh_b_d = sh_b_q >> NIB_W;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        // Last nibble is the most significant, so its cascade output is final.
        if (cnt_q == CNT_W'(NIB - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = cmp_c;
          state_d = ST_DONE;
          if (cmp_c == CMP_LT) begin
            max_d = hold_b_q;
            min_d = hold_a_q;
          end else begin
            max_d = hold_a_q;
            min_d = hold_b_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oData = data_q;
  assign oMax  = max_q;
  assign oMin  = min_q;

endmodule

// File: tb/tb_data_compare_seq.sv
// Directed bench for data_compare_seq with WIDTH=16 (four nibble steps).
module tb_data_compare_seq;

  logic        iClk;
  logic        iRst_n;
  logic        iStart;
  logic [15:0] iData_a;
  logic [15:0] iData_b;
  logic        oBusy;
  logic        oDone;
  logic [2:0]  oData;
  logic [15:0] oMax;
  logic [15:0] oMin;

  int n_checks;
  int n_fails;

  data_compare_seq #(.WIDTH(16)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData),
    .oMax    (oMax),
    .oMin    (oMin)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic busy, input logic done);
    chk({tag, "_busy"}, 16'(oBusy), 16'(busy));
    chk({tag, "_done"}, 16'(oDone), 16'(done));
  endtask

  task automatic chk_res(input string tag, input logic [2:0] d, input logic [15:0] mx,
                         input logic [15:0] mn);
    chk({tag, "_data"}, 16'(oData), 16'(d));
    chk({tag, "_max"}, oMax, mx);
    chk({tag, "_min"}, oMin, mn);
  endtask

  // Single start/complete transaction with full latency checks.
  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] d, input logic [15:0] mx, input logic [15:0] mn);
    iStart  = 1'b1;
    iData_a = a;
    iData_b = b;
    tick();                       // edge T
    iStart = 1'b0;
    chk_flags({tag, "_T"}, 1'b1, 1'b0);
    repeat (3) tick();            // T+3
    chk_flags({tag, "_T3"}, 1'b1, 1'b0);
    tick();                       // T+4
    chk_flags({tag, "_T4"}, 1'b0, 1'b1);
    chk_res(tag, d, mx, mn);
    tick();                       // T+5
    chk_flags({tag, "_T5"}, 1'b0, 1'b0);
    chk_res({tag, "_hold"}, d, mx, mn);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    iRst_n   = 1'b0;
    iStart   = 1'b0;
    iData_a  = '0;
    iData_b  = '0;
    repeat (2) tick();
    chk_flags("rst", 1'b0, 1'b0);
    chk_res("rst", 3'b000, 16'h0000, 16'h0000);
    iRst_n = 1'b1;
    tick();

    run_cmp("low_nib", 16'h1234, 16'h1233, 3'b100, 16'h1234, 16'h1233);
    run_cmp("msb_ovr", 16'h0FFF, 16'h1000, 3'b010, 16'h1000, 16'h0FFF);
    run_cmp("equal",   16'hA5A5, 16'hA5A5, 3'b001, 16'hA5A5, 16'hA5A5);

    // Start pulse during RUN must be ignored.
    iStart  = 1'b1;
    iData_a = 16'h0001;
    iData_b = 16'h0002;
    tick();                       // T
    iStart = 1'b0;
    tick();                       // T+1
    iStart  = 1'b1;
    iData_a = 16'hFFFF;
    iData_b = 16'h0000;
    tick();                       // T+2
    iStart = 1'b0;
    chk_flags("ign_T2", 1'b1, 1'b0);
    tick();                       // T+3
    chk_flags("ign_T3", 1'b1, 1'b0);
    tick();                       // T+4
    chk_flags("ign_T4", 1'b0, 1'b1);
    chk_res("ign", 3'b010, 16'h0002, 16'h0001);
    tick();                       // T+5
    chk_flags("ign_T5", 1'b0, 1'b0);
    repeat (2) tick();
    chk_flags("ign_T7", 1'b0, 1'b0);

    // Back-to-back with iStart held high: one result every 5 cycles.
    iStart  = 1'b1;
    iData_a = 16'h0005;
    iData_b = 16'h0003;
    tick();                       // accept pair0
    iData_a = 16'h0300;
    iData_b = 16'h0500;
    repeat (3) tick();
    chk_flags("b2b0_pre", 1'b1, 1'b0);
    tick();
    chk_flags("b2b0", 1'b0, 1'b1);
    chk_res("b2b0", 3'b100, 16'h0005, 16'h0003);
    tick();                       // pair1 accepted in DONE
    chk_flags("b2b1_acc", 1'b1, 1'b0);
    chk_res("b2b0_keep", 3'b100, 16'h0005, 16'h0003);
    iData_a = 16'h7000;
    iData_b = 16'h6FFF;
    repeat (4) tick();
    chk_flags("b2b1", 1'b0, 1'b1);
    chk_res("b2b1", 3'b010, 16'h0500, 16'h0300);
    tick();                       // pair2 accepted
    iStart = 1'b0;
    chk_flags("b2b2_acc", 1'b1, 1'b0);
    repeat (4) tick();
    chk_flags("b2b2", 1'b0, 1'b1);
    chk_res("b2b2", 3'b100, 16'h7000, 16'h6FFF);
    tick();
    chk_flags("b2b_end", 1'b0, 1'b0);

    // Reset in the middle of RUN clears everything and suppresses oDone.
    iStart  = 1'b1;
    iData_a = 16'h00FF;
    iData_b = 16'h0F00;
    tick();                       // T
    iStart = 1'b0;
    repeat (2) tick();            // T+2
    iRst_n = 1'b0;
    #1;
    chk_flags("mrst", 1'b0, 1'b0);
    chk_res("mrst", 3'b000, 16'h0000, 16'h0000);
    repeat (3) tick();
    chk_flags("mrst_hold", 1'b0, 1'b0);
    iRst_n = 1'b1;
    tick();
    chk_flags("mrst_rel", 1'b0, 1'b0);
    run_cmp("post_rst", 16'h8000, 16'h7FFF, 3'b100, 16'h8000, 16'h7FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
